rot_share_arbiter: RTL and testbench
====================================

Name: rot_share_arbiter

Overview:
- Shares one combinational 4-bit rotator (ports in, shift, q) between two requesters.
- Arbitrates round-robin, accepts one rotate request per transaction through a valid/ready handshake, and drives the rotator from registered operands.
- Captures the rotator's result and returns it with the requester ID on a valid/ready response channel.
- Sits between the two client blocks and the single rotator instance, which lives outside this block.

Parameters:
- WIDTH, 4, data width of the rotator operand and result.
- SHW, 2, width of the rotate amount; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  request from requester 0 accepted this cycle.
- req0_data  input  WIDTH  operand from requester 0.
- req0_shift  input  SHW  rotate amount from requester 0.
- req1_valid, req1_ready, req1_data, req1_shift  same as requester 0, for requester 1.
- sh_in  output  WIDTH  operand driven to the rotator's in.
- sh_shift  output  SHW  amount driven to the rotator's shift.
- sh_q  input  WIDTH  rotator result (q); combinational from sh_in and sh_shift.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  WIDTH  captured rotator result.
- rsp_id  output  1  requester that issued the request (0 or 1).
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sh_in=0, sh_shift=0, rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (requester 0 wins the first tie), busy=0.
- Reset mid-transaction drops the in-flight request and any unconsumed response without notice.
- FSM states: IDLE, EXEC, RESP.
- IDLE arbitration:
  - Only req0_valid high: grant 0. Only req1_valid high: grant 1.
  - Both high: grant the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && granted==N. Combinational; at most one ready high; never high outside IDLE.
- Acceptance (valid && ready on a rising edge):
  - Latch the requester's data into sh_in and shift into sh_shift.
  - Latch the grant ID into an internal id register and into last_grant.
  - Go to EXEC.
- EXEC (one cycle): the rotator settles. On the edge, rsp_data<=sh_q, rsp_id<=id, rsp_valid<=1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready.
  - On the edge with rsp_ready=1: rsp_valid<=0, go to IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- sh_in and sh_shift hold their last accepted values until the next acceptance; they do not return to 0 after a transaction.
- Latency: accept on edge N, rsp_valid high after edge N+1, i.e. 2 cycles to first observation.
- Throughput: one transaction per 3 cycles at most when rsp_ready is held high.
- Request rules:
  - A request not granted stays pending; requesters must hold valid and data until ready.
  - A request deasserted before grant is simply not served.
  - No request is ever accepted while a response is outstanding.
- Rotator contract: q = in rotated right by shift. shift=0 passes in through unchanged. The block does not recompute or check q.
- Arithmetic: no width growth; all fields pass through unmodified.

Test Plan:
- Reset release, both requests idle -> all outputs 0, busy=0, both readies 0, rsp_valid=0 indefinitely.
- req0 only, data=4'b0001, shift=1, rsp_ready=1 -> req0_ready pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_data=4'b1000, rsp_id=0; busy returns 0 one cycle after the response handshake.
- Both requesters valid continuously after reset (req0 data=4'b0010 shift=2; req1 data=4'b0100 shift=3) -> grants alternate 0,1,0,1; responses are 4'b1000 id0 and 4'b1000 id1 alternately; no requester is granted twice in a row.
- req1 data=4'b1000 shift=3, rsp_ready held 0 for 5 cycles -> rsp_valid=1, rsp_data=4'b0001, rsp_id=1 stable for all 5 cycles; req0_valid asserted meanwhile gets no ready until one cycle after rsp_ready rises.
- Sweep data=4'b0001,0010,0100,1000 x shift=0..3 through req0 -> rsp_data equals the right-rotated operand for all 16 cases; shift=0 returns the operand unchanged.
- rst_n pulled low while in EXEC -> outputs reset asynchronously; no response appears after rst_n rises; a new req0 is then granted normally.

Source files
------------

// File: rtl/rot_share_arbiter_if.sv
// Bundle of the request, rotator and response signals around rot_share_arbiter.
// The arbiter uses the slave modport and its surroundings use the master modport.
interface rot_share_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [SHW-1:0]   req0_shift;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [SHW-1:0]   req1_shift;
  logic [WIDTH-1:0] sh_in;
  logic [SHW-1:0]   sh_shift;
  logic [WIDTH-1:0] sh_q;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_data, req0_shift,
    input  req1_valid, req1_data, req1_shift,
    input  sh_q, rsp_ready,
    output req0_ready, req1_ready, sh_in, sh_shift,
    output rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req0_valid, req0_data, req0_shift,
    output req1_valid, req1_data, req1_shift,
    output sh_q, rsp_ready,
    input  req0_ready, req1_ready, sh_in, sh_shift,
    input  rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/rot_share_arbiter.sv
// Round-robin share of one external combinational rotator between two requesters,
// returning the registered result and requester id on a valid/ready response channel.
//
// state | meaning
// IDLE  | arbitrating; the granted requester sees ready
// EXEC  | operands registered, external rotator settling
// RESP  | result held on the response channel until rsp_ready
module rot_share_arbiter #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rot_share_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_in_q, sh_in_d;
  logic [SHW-1:0]   sh_shift_q, sh_shift_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;

  logic grant_vld;
  logic grant_id;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~last_grant_q;
    end else if (bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end else if (bus.req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    sh_in_d      = sh_in_q;
    sh_shift_d   = sh_shift_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          sh_in_d      = grant_id ? bus.req1_data  : bus.req0_data;
          sh_shift_d   = grant_id ? bus.req1_shift : bus.req0_shift;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = bus.sh_q;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sh_in_q      <= '0;
      sh_shift_q   <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_in_q      <= sh_in_d;
      sh_shift_q   <= sh_shift_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.req0_ready = (state_q == ST_IDLE) && grant_vld && !grant_id;
  assign bus.req1_ready = (state_q == ST_IDLE) && grant_vld &&  grant_id;
  assign bus.sh_in      = sh_in_q;
  assign bus.sh_shift   = sh_shift_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_rot_share_arbiter.sv
// Directed bench for rot_share_arbiter with a behavioural rotator on sh_in/sh_shift.
module tb_rot_share_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [3:0] exp_tbl [16];
  logic [7:0] rot_tmp;

  rot_share_arbiter_if #(.WIDTH(4), .SHW(2)) bus ();

  rot_share_arbiter #(.WIDTH(4), .SHW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External rotator: right rotate of sh_in by sh_shift.
  always_comb begin
    rot_tmp  = {bus.sh_in, bus.sh_in} >> bus.sh_shift;
    bus.sh_q = rot_tmp[3:0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_tbl = '{4'b0001, 4'b1000, 4'b0100, 4'b0010,
                4'b0010, 4'b0001, 4'b1000, 4'b0100,
                4'b0100, 4'b0010, 4'b0001, 4'b1000,
                4'b1000, 4'b0100, 4'b0010, 4'b0001};
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = 4'h0; bus.req0_shift = 2'd0;
    bus.req1_valid = 1'b0; bus.req1_data = 4'h0; bus.req1_shift = 2'd0;
    bus.rsp_ready  = 1'b0;

    // reset and idle
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_busy",   {7'd0, bus.busy},       8'h0);
      chk("idle_rdy0",   {7'd0, bus.req0_ready}, 8'h0);
      chk("idle_rdy1",   {7'd0, bus.req1_ready}, 8'h0);
      chk("idle_rspv",   {7'd0, bus.rsp_valid},  8'h0);
      chk("idle_shin",   {4'd0, bus.sh_in},      8'h0);
      chk("idle_shsh",   {6'd0, bus.sh_shift},   8'h0);
      chk("idle_rspd",   {4'd0, bus.rsp_data},   8'h0);
      chk("idle_rspid",  {7'd0, bus.rsp_id},     8'h0);
      cyc();
    end

    // single req0: 0001 ror 1 = 1000
    bus.req0_valid = 1'b1; bus.req0_data = 4'b0001; bus.req0_shift = 2'd1;
    bus.rsp_ready  = 1'b1;
    #1;
    chk("t2_rdy0", {7'd0, bus.req0_ready}, 8'h1);
    chk("t2_rdy1", {7'd0, bus.req1_ready}, 8'h0);
    cyc();
    bus.req0_valid = 1'b0;
    #1;
    chk("t2_exec_rdy0", {7'd0, bus.req0_ready}, 8'h0);
    chk("t2_exec_busy", {7'd0, bus.busy},       8'h1);
    chk("t2_exec_shin", {4'd0, bus.sh_in},      8'h1);
    chk("t2_exec_shsh", {6'd0, bus.sh_shift},   8'h1);
    chk("t2_exec_rspv", {7'd0, bus.rsp_valid},  8'h0);
    cyc();
    chk("t2_rspv",  {7'd0, bus.rsp_valid}, 8'h1);
    chk("t2_rspd",  {4'd0, bus.rsp_data},  8'h8);
    chk("t2_rspid", {7'd0, bus.rsp_id},    8'h0);
    chk("t2_busy",  {7'd0, bus.busy},      8'h1);
    cyc();
    chk("t2_done_busy", {7'd0, bus.busy},      8'h0);
    chk("t2_done_rspv", {7'd0, bus.rsp_valid}, 8'h0);
    chk("t2_hold_shin", {4'd0, bus.sh_in},     8'h1);

    // fresh reset, then both requesters continuously valid
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 4'b0010; bus.req0_shift = 2'd2;
    bus.req1_valid = 1'b1; bus.req1_data = 4'b0100; bus.req1_shift = 2'd3;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_rdy0", {7'd0, bus.req0_ready}, (k % 2 == 0) ? 8'h1 : 8'h0);
      chk("t3_rdy1", {7'd0, bus.req1_ready}, (k % 2 == 0) ? 8'h0 : 8'h1);
      cyc();
      chk("t3_exec_rdy", {6'd0, bus.req1_ready, bus.req0_ready}, 8'h0);
      cyc();
      chk("t3_rspv",  {7'd0, bus.rsp_valid}, 8'h1);
      chk("t3_rspd",  {4'd0, bus.rsp_data},  8'h8);
      chk("t3_rspid", {7'd0, bus.rsp_id},    (k % 2 == 0) ? 8'h0 : 8'h1);
      cyc();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // req1 with stalled consumer; req0 waits behind the response
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 4'b1000; bus.req1_shift = 2'd3;
    #1;
    chk("t4_rdy1", {7'd0, bus.req1_ready}, 8'h1);
    cyc();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 4'b0001; bus.req0_shift = 2'd0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_rspv",  {7'd0, bus.rsp_valid},  8'h1);
      chk("t4_rspd",  {4'd0, bus.rsp_data},   8'h1);
      chk("t4_rspid", {7'd0, bus.rsp_id},     8'h1);
      chk("t4_rdy0",  {7'd0, bus.req0_ready}, 8'h0);
      if (i < 4) cyc();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t4_rdy0_same", {7'd0, bus.req0_ready}, 8'h0);
    cyc();
    #1;
    chk("t4_rdy0_after", {7'd0, bus.req0_ready}, 8'h1);
    chk("t4_rspv_after", {7'd0, bus.rsp_valid},  8'h0);
    cyc();
    bus.req0_valid = 1'b0;
    cyc();
    chk("t4_r0_rspd",  {4'd0, bus.rsp_data}, 8'h1);
    chk("t4_r0_rspid", {7'd0, bus.rsp_id},   8'h0);
    cyc();

    // sweep all one-hot operands and shifts through req0
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < 4; s++) begin
        bus.req0_valid = 1'b1;
        bus.req0_data  = 4'(1 << i);
        bus.req0_shift = 2'(s);
        #1;
        chk("t5_rdy0", {7'd0, bus.req0_ready}, 8'h1);
        cyc();
        bus.req0_valid = 1'b0;
        cyc();
        chk("t5_rspd",  {4'd0, bus.rsp_data}, {4'd0, exp_tbl[i*4+s]});
        chk("t5_rspid", {7'd0, bus.rsp_id},   8'h0);
        cyc();
      end
    end

    // asynchronous reset while in EXEC
    bus.req0_valid = 1'b1; bus.req0_data = 4'b0011; bus.req0_shift = 2'd1;
    cyc();
    bus.req0_valid = 1'b0;
    #1;
    chk("t6_pre_busy", {7'd0, bus.busy}, 8'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", {7'd0, bus.busy},      8'h0);
    chk("t6_rst_rspv", {7'd0, bus.rsp_valid}, 8'h0);
    chk("t6_rst_shin", {4'd0, bus.sh_in},     8'h0);
    chk("t6_rst_shsh", {6'd0, bus.sh_shift},  8'h0);
    chk("t6_rst_rspd", {4'd0, bus.rsp_data},  8'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_no_rsp", {7'd0, bus.rsp_valid}, 8'h0);
      chk("t6_idle",   {7'd0, bus.busy},      8'h0);
    end
    bus.req0_valid = 1'b1; bus.req0_data = 4'b0110; bus.req0_shift = 2'd2;
    #1;
    chk("t6_rdy0", {7'd0, bus.req0_ready}, 8'h1);
    cyc();
    bus.req0_valid = 1'b0;
    cyc();
    chk("t6_rspv",  {7'd0, bus.rsp_valid}, 8'h1);
    chk("t6_rspd",  {4'd0, bus.rsp_data},  8'h9);
    chk("t6_rspid", {7'd0, bus.rsp_id},    8'h0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
